// File: rtl/mult_issue.sv
// Multiply issue stage: accepts a signed multiply from decode, sequences
// the external mult32 unit (CLEAR, RUN) and presents the result on a
// valid/ready writeback port.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_ready         request handshake from decode
//   in_a, in_b, in_rd          operands and destination tag
//   flush                      pipeline kill, aborts any in-flight request
//   m_mcnd, m_mplr             operands to the multiplier
//   m_ctrl, m_on               multiplier clear / run enable
//   m_result, m_e, m_rdy       multiplier result, exception, done
//   wb_valid, wb_ready         writeback handshake
//   wb_data, wb_rd, wb_exc     writeback payload
//   stall                      high whenever a request is in flight
module mult_issue #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] m_mcnd,
    output logic [31:0] m_mplr,
    output logic        m_ctrl,
    output logic        m_on,
    input  logic [31:0] m_result,
    input  logic        m_e,
    input  logic        m_rdy,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_exc,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    // Last watchdog value before the forced timeout; the watchdog starts at
    // 0 on the first RUN cycle, so this yields TIMEOUT RUN cycles in total.
    localparam logic [5:0] WD_LAST = 6'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] hold_a;
    logic [31:0] hold_b;
    logic [4:0]  hold_rd;
    logic [31:0] data_q;
    logic        exc_q;
    logic [5:0]  wd;
    logic        clr_q;
    logic        zero_op;
    logic        timeout;

    assign zero_op = (in_a == 32'd0) || (in_b == 32'd0);
    assign timeout = (wd == WD_LAST);

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_nx = zero_op ? DONE : CLEAR;
                    end
                end
                CLEAR: state_nx = RUN;
                RUN: begin
                    if (m_rdy || timeout) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            hold_a  <= '0;
            hold_b  <= '0;
            hold_rd <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
            wd      <= '0;
            clr_q   <= 1'b1;
        end else begin
            state <= state_nx;
            // One-cycle clear pulse when a flush kills a running multiply.
            clr_q <= flush && (state == RUN);
            if (!flush) begin
                unique case (state)
                    IDLE: begin
                        if (in_valid) begin
                            hold_a  <= in_a;
                            hold_b  <= in_b;
                            hold_rd <= in_rd;
                            data_q  <= '0;
                            exc_q   <= 1'b0;
                        end
                    end
                    CLEAR: wd <= '0;
                    RUN: begin
                        wd <= wd + 6'd1;
                        if (m_rdy) begin
                            data_q <= m_result;
                            exc_q  <= m_e;
                        end else if (timeout) begin
                            data_q <= '0;
                            exc_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready = (state == IDLE);
    assign stall    = (state != IDLE);
    assign m_mcnd   = hold_a;
    assign m_mplr   = hold_b;
    assign m_ctrl   = (state == CLEAR) || clr_q;
    assign m_on     = (state == RUN);
    assign wb_valid = (state == DONE);
    assign wb_data  = data_q;
    assign wb_exc   = exc_q;
    assign wb_rd    = hold_rd;

endmodule

// File: tb/tb_mult_issue.sv
// Directed bench for mult_issue with a behavioural multiplier model and a
// writeback scoreboard drained by an independent monitor.
module tb_mult_issue;

    typedef struct packed {
        logic [31:0] data;
        logic        exc;
        logic [4:0]  rd;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        in_ready;
    logic        flush;
    logic [31:0] m_mcnd;
    logic [31:0] m_mplr;
    logic        m_ctrl;
    logic        m_on;
    logic [31:0] m_result;
    logic        m_e;
    logic        m_rdy;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exc;
    logic        stall;

    int checks = 0;
    int errors = 0;
    wb_t sb[$];

    // Multiplier model: asserts m_rdy on RUN cycle mdl_lat when enabled.
    int          run_cnt = 0;
    int          mdl_lat = 1;
    logic        mdl_en = 1'b1;
    logic [31:0] mdl_result = '0;
    logic        mdl_e = 1'b0;
    logic        stray_rdy = 1'b0;
    logic        mon_seen = 1'b0;

    mult_issue #(.TIMEOUT(63)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_a(in_a),
        .in_b(in_b),
        .in_rd(in_rd),
        .in_ready(in_ready),
        .flush(flush),
        .m_mcnd(m_mcnd),
        .m_mplr(m_mplr),
        .m_ctrl(m_ctrl),
        .m_on(m_on),
        .m_result(m_result),
        .m_e(m_e),
        .m_rdy(m_rdy),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_data(wb_data),
        .wb_rd(wb_rd),
        .wb_exc(wb_exc),
        .stall(stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_ctrl || !m_on) run_cnt <= 0;
        else run_cnt <= run_cnt + 1;
    end

    assign m_rdy = (m_on && mdl_en && run_cnt == mdl_lat - 1) || stray_rdy;
    assign m_result = mdl_result;
    assign m_e = mdl_e;

    always @(negedge clk) if (m_on) mon_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every completed writeback must match the oldest
    // expected entry; a writeback with nothing expected is an error.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_exc", {31'd0, wb_exc}, {31'd0, e.exc});
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("issue_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_rd = rd;
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the acceptance edge; reports the cycle index
    // (acceptance cycle = 0) at which wb_valid is first seen.
    task automatic wait_wb(input string name, input int exp_lat);
        int cyc = 1;
        while (!wb_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check(name, cyc, exp_lat);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_rd = '0;
        flush = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_exc", {31'd0, wb_exc}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_m_on", {31'd0, m_on}, 32'd0);
        check("rst_m_ctrl", {31'd0, m_ctrl}, 32'd1);
        check("rst_mcnd", m_mcnd, 32'd0);
        check("rst_mplr", m_mplr, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // 7 * -3 = -21, 17 RUN cycles
        mdl_lat = 17;
        mdl_result = 32'hFFFF_FFEB;
        mdl_e = 1'b0;
        sb.push_back('{32'hFFFF_FFEB, 1'b0, 5'd5});
        issue(32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_wb("lat_normal", 19);
        check("mcnd_held", m_mcnd, 32'd7);
        check("mplr_held", m_mplr, 32'hFFFF_FFFD);
        check("m_on_done", {31'd0, m_on}, 32'd0);
        tick();

        // zero operand shortcut
        mon_seen = 1'b0;
        sb.push_back('{32'd0, 1'b0, 5'd9});
        issue(32'd0, 32'h1234_5678, 5'd9);
        wait_wb("lat_zero", 1);
        tick();
        check("zero_no_run", {31'd0, mon_seen}, 32'd0);

        // overflow with m_e, writeback back-pressured for 5 cycles
        wb_ready = 1'b0;
        mdl_lat = 4;
        mdl_result = 32'd0;
        mdl_e = 1'b1;
        sb.push_back('{32'd0, 1'b1, 5'd3});
        issue(32'h4000_0000, 32'd4, 5'd3);
        wait_wb("lat_exc", 6);
        mdl_result = 32'h0BAD_0BAD;
        mdl_e = 1'b0;
        stray_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, wb_valid}, 32'd1);
            check("hold_data", wb_data, 32'd0);
            check("hold_exc", {31'd0, wb_exc}, 32'd1);
            check("hold_rd", {27'd0, wb_rd}, 32'd3);
            check("hold_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        stray_rdy = 1'b0;
        wb_ready = 1'b1;
        tick();
        check("release_stall", {31'd0, stall}, 32'd0);

        // flush during RUN cycle 5
        mdl_lat = 40;
        issue(32'd5, 32'd6, 5'd7);
        for (int i = 0; i < 5; i++) tick();
        check("flush_run", {31'd0, m_on}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {31'd0, stall}, 32'd0);
        check("flush_ctrl", {31'd0, m_ctrl}, 32'd1);
        check("flush_m_on", {31'd0, m_on}, 32'd0);
        check("flush_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        check("flush_ctrl_end", {31'd0, m_ctrl}, 32'd0);
        mdl_lat = 3;
        mdl_result = 32'd30;
        mdl_e = 1'b0;
        sb.push_back('{32'd30, 1'b0, 5'd8});
        issue(32'd5, 32'd6, 5'd8);
        wait_wb("lat_after_flush", 5);
        tick();

        // multiplier never answers: watchdog timeout
        mdl_en = 1'b0;
        sb.push_back('{32'd0, 1'b1, 5'd12});
        issue(32'd3, 32'd4, 5'd12);
        wait_wb("lat_timeout", 65);
        tick();
        mdl_en = 1'b1;

        // reset while DONE holds a result
        wb_ready = 1'b0;
        mdl_lat = 2;
        mdl_result = 32'd4;
        issue(32'd2, 32'd2, 5'd1);
        wait_wb("lat_pre_reset", 4);
        rst_n = 1'b0;
        tick();
        check("rst_done_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_done_ctrl", {31'd0, m_ctrl}, 32'd1);
        check("rst_done_data", wb_data, 32'd0);
        rst_n = 1'b1;
        check("rst_done_ready", {31'd0, in_ready}, 32'd1);
        wb_ready = 1'b1;
        tick();

        sb.push_back('{32'd0, 1'b0, 5'd2});
        issue(32'h55, 32'd0, 5'd2);
        wait_wb("lat_zero_b", 1);
        tick();
        tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_issue.md
MULT_ISSUE -- requirements
Module: mult_issue

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1: synchronous active-low reset.
REQ-004 Port in_valid, input, 1: decode stage presents a multiply request.
REQ-005 Port in_a / in_b, input, 32 each: signed multiplicand / multiplier.
REQ-006 Port in_rd, input, 5: destination register tag.
REQ-007 Port in_ready, output, 1: block accepts a request this cycle.
REQ-008 Port flush, input, 1: pipeline kill; aborts any in-flight request.
REQ-009 Port m_mcnd / m_mplr, output, 32 each: operands driven to the mult32 unit.
REQ-010 Port m_ctrl, output, 1: multiplier clear, active high.
REQ-011 Port m_on, output, 1: multiplier run enable.
REQ-012 Port m_result, input, 32; m_e, input, 1; m_rdy, input, 1: multiplier outputs.
REQ-013 Port wb_valid, output, 1; wb_ready, input, 1: writeback handshake.
REQ-014 Port wb_data, output, 32; wb_rd, output, 5; wb_exc, output, 1: writeback payload.
REQ-015 Port stall, output, 1: high whenever state is not IDLE.
REQ-016 Parameter TIMEOUT, default 63: maximum RUN cycles before the block forces a timeout exception.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, RUN, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 On in_valid&in_ready&!flush, the block SHALL register in_a, in_b, in_rd into holding registers.
- Next state is DONE if either operand == 0; otherwise CLEAR.
REQ-020 m_mcnd/m_mplr SHALL be driven from the holding registers, stable from acceptance until leaving DONE.
REQ-021 CLEAR SHALL last exactly 1 cycle with m_ctrl=1 and m_on=0, then go to RUN.
REQ-022 In RUN, m_on SHALL be 1, m_ctrl=0, and a 6-bit watchdog SHALL increment each cycle from 0.
REQ-023 In RUN, m_rdy=1 SHALL capture m_result→wb_data and m_e→wb_exc, then go to DONE; the following cycle m_on SHALL be 0.
REQ-024 If the watchdog reaches TIMEOUT without m_rdy, the block SHALL go to DONE with wb_data=0 and wb_exc=1.
REQ-025 Zero-operand shortcut: wb_data=0, wb_exc=0, the multiplier is never started, and latency from acceptance to wb_valid is 1 cycle.
REQ-026 Normal latency SHALL be acceptance + 1 (CLEAR) + multiplier cycles to m_rdy + 1 (to wb_valid).
REQ-027 In DONE, wb_valid SHALL be 1, with payload and wb_rd held stable until wb_ready=1.
- wb_valid&wb_ready returns the block to IDLE.
- A new request cannot be accepted in that same cycle.
REQ-028 flush=1 in any state SHALL:
- force IDLE next cycle;
- drop wb_valid without a writeback;
- pulse m_ctrl=1 for 1 cycle when leaving RUN.
REQ-029 flush SHALL take priority over acceptance, m_rdy, timeout and wb_ready in the same cycle.
REQ-030 m_rdy or m_e arriving outside RUN SHALL be ignored.
REQ-031 stall SHALL be combinationally equal to (state != IDLE).

Reset
REQ-032 With rst_n=0 at a rising edge, the block SHALL enter IDLE, with the following output values:
- wb_valid=0, wb_exc=0;
- wb_data=0, wb_rd=0;
- m_on=0, m_ctrl=1 (multiplier held clear);
- holding registers=0, watchdog=0.
REQ-033 Reset mid-operation SHALL discard the request with no writeback.
REQ-034 in_ready SHALL be 1 on the first cycle after rst_n returns high.

Verification
REQ-035 in_a=7, in_b=-3, multiplier model asserts m_rdy after 17 RUN cycles with m_result=-21 -> wb_valid after 19 cycles, wb_data=0xFFFFFFEB, wb_exc=0.
REQ-036 in_a=0, in_b=0x12345678 -> m_on never 1, wb_valid next cycle, wb_data=0, wb_exc=0.
REQ-037 in_a=0x40000000, in_b=4, model returns m_e=1 -> wb_exc=1; wb_ready held 0 for 5 cycles -> payload stable, stall=1 throughout.
REQ-038 flush at RUN cycle 5 -> IDLE next cycle, m_ctrl pulse 1 cycle, no wb_valid; a new request is then accepted and completes correctly.
REQ-039 Model never asserts m_rdy -> after 63 RUN cycles wb_valid=1, wb_data=0, wb_exc=1.
REQ-040 rst_n=0 during DONE with wb_valid=1 -> next cycle wb_valid=0, m_ctrl=1, in_ready=1 after rst_n rises.
